// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit (md_unit).
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_DIVU  = 2'b01,
        MD_MTHI  = 2'b10,
        MD_MTLO  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIN  = 2'b11
    } md_state_e;

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned md_cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module md_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] trial;

    always_comb begin
        trial = {rem_i, dvd_bit_i};
        q_o   = (trial >= {2'b00, div_i});
        rem_o = q_o ? (WIDTH+1)'(trial - {2'b00, div_i}) : trial[WIDTH:0];
    end

endmodule

// File: rtl/md_unit.sv
// Iterative MULTU/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional: define MD_EARLY_OUT_EN to finish MULTU once remaining multiplier bits are zero.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = md_cnt_width(WIDTH);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               last;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_res;
    logic               mul_fin;
    logic [WIDTH:0]     div_rem;
    logic               div_q;
    logic [WIDTH-1:0]   quo_next;
`ifdef MD_EARLY_OUT_EN
    logic [WIDTH-1:0]   mul_rest;
`endif

    // prod_q low half holds the dividend during DIV, shifting quotient bits in from the LSB.
    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .dvd_bit_i (prod_q[WIDTH-1]),
        .div_i     (opb_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    always_comb begin
        last     = (cnt_q == CNT_W'(WIDTH - 1));
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
        quo_next = {prod_q[WIDTH-2:0], div_q};
`ifdef MD_EARLY_OUT_EN
        // After cnt+1 steps the partial product sits WIDTH-1-cnt bits too high.
        mul_rest = opb_q >> (32'(cnt_q) + 32'd1);
        mul_fin  = last || (mul_rest == '0);
        mul_res  = mul_next >> (WIDTH - 1 - 32'(cnt_q));
`else
        mul_fin  = last;
        mul_res  = mul_next;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            MUL: begin
                busy   = 1'b1;
                prod_d = mul_next;
                if (mul_fin) begin
                    state_d = FIN;
                    hi_d    = mul_res[2*WIDTH-1:WIDTH];
                    lo_d    = mul_res[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV: begin
                busy                = 1'b1;
                prod_d[WIDTH-1:0]   = quo_next;
                rem_d               = div_rem;
                if (last) begin
                    state_d = FIN;
                    hi_d    = div_rem[WIDTH-1:0];
                    lo_d    = quo_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start && !busy) begin
            case (md_op_e'(op))
                MD_MULTU: begin
                    state_d = MUL;
                    cnt_d   = '0;
                    opa_d   = A;
                    opb_d   = B;
                    prod_d  = {{WIDTH{1'b0}}, B};
`ifdef MD_EARLY_OUT_EN
                    if (B == '0) begin
                        state_d = FIN;
                        hi_d    = '0;
                        lo_d    = '0;
                    end
`endif
                end
                MD_DIVU: begin
                    opb_d = B;
                    if (B == '0) begin
                        state_d = FIN;
                        hi_d    = A;
                        lo_d    = '1;
                    end else begin
                        state_d = DIV;
                        cnt_d   = '0;
                        rem_d   = '0;
                        prod_d  = {{WIDTH{1'b0}}, A};
                    end
                end
                MD_MTHI: begin
                    state_d = IDLE;
                    hi_d    = A;
                end
                MD_MTLO: begin
                    state_d = IDLE;
                    lo_d    = A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers. It is the sequential counterpart of the combinational ALU's MULTU/DIVU paths.
- The pipeline EX stage issues an operation with a start pulse. The unit iterates one bit per cycle, then commits the 2*WIDTH result to HI/LO.
- The pipeline stalls on busy and reads HI/LO directly for MFHI/MFLO.
- Also services MTHI/MTLO single-cycle writes.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  issue request; sampled only when busy=0
- op  in  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- A  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- B  in  WIDTH  multiplier / divisor (ignored for MTHI/MTLO)
- busy  out  1  high while iterating; pipeline stalls on it
- done  out  1  one-cycle pulse when a MULTU/DIVU result is committed
- hi  out  WIDTH  HI register (MULTU upper product / DIVU remainder)
- lo  out  WIDTH  LO register (MULTU lower product / DIVU quotient)

Behaviour:
- Reset (synchronous, active-high; clk, rst): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset mid-operation aborts the operation with no partial commit.
- States:
  - IDLE: busy=0.
  - MUL: busy=1.
  - DIV: busy=1.
  - FIN: busy=0, done=1.
- Transitions:
  - IDLE or FIN, start=1, op=MULTU -> MUL.
  - IDLE or FIN, start=1, op=DIVU, B!=0 -> DIV.
  - IDLE or FIN, start=1, op=DIVU, B=0 -> FIN (divide-by-zero path).
  - MTHI/MTLO: state -> IDLE; at the same edge write hi<=A or lo<=A. No busy, no done.
  - MUL or DIV with counter == WIDTH-1 -> FIN. Otherwise increment the counter.
  - FIN with no start -> IDLE.
- Operand capture: A and B are latched at the accepting edge. Later changes on the inputs have no effect.
- MUL: unsigned shift-add, 2*WIDTH accumulator, one multiplier bit per cycle (LSB first).
- DIV: unsigned restoring division, one quotient bit per cycle (MSB first). The remainder register is WIDTH+1 bits internally.
- Latency:
  - start sampled at edge T.
  - busy=1 during cycles T+1 .. T+WIDTH.
  - hi/lo updated and done=1 in cycle T+WIDTH+1.
- hi/lo stay stable during iteration; they change only at the commit edge or on an MT write.
- Divide by zero:
  - FIN is reached in cycle T+1.
  - lo = all ones; hi = A.
- start while busy=1 is ignored (not queued). The initiator must hold the request until busy=0.
- start in FIN is accepted: done=1 for that cycle and the new operation begins. Back-to-back operations are allowed.
- Results are modulo 2^WIDTH per half. There are no overflow flags.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: MUL goes to FIN early once the remaining unshifted multiplier bits are all zero. The accumulator is aligned by the remaining shift count before commit.
  - Example: B=1 commits in cycle T+2; B=0 commits in cycle T+1.
  - DIV timing is unchanged.
- Undefined: MUL always takes WIDTH iteration cycles.
- Results are identical with and without the macro; only latency differs.

Decomposition:
- Package md_pkg:
  - op encodings MD_MULTU, MD_DIVU, MD_MTHI, MD_MTLO;
  - state encodings IDLE, MUL, DIV, FIN;
  - counter width constant $clog2(WIDTH).
- Sub-module md_div_step: combinational restoring step. It takes the partial remainder and divisor and returns the next remainder and quotient bit; it is instantiated once. The MUL step stays inline.

Test Plan:
- Reset mid-MUL: MULTU with A=7, B=9, assert rst in cycle T+10 -> busy=0, hi=0, lo=0, done never pulses.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy high for exactly 32 cycles; in cycle T+33 done=1, hi=0xFFFFFFFE, lo=0x00000001.
- DIVU A=100, B=7 -> lo=14, hi=2 at T+33. DIVU A=0x80000000, B=1 -> lo=0x80000000, hi=0.
- DIVU A=0x1234, B=0 -> done=1 in cycle T+1, lo=0xFFFFFFFF, hi=0x1234.
- MTHI A=0xAAAA then MTLO A=0x5555 on consecutive cycles -> hi=0xAAAA, lo=0x5555, busy=0 and done=0 throughout. A start pulse with op=DIVU mid-MUL is ignored, and the MUL result is unchanged.
- Back-to-back: start MULTU 3*5 in the FIN cycle of a prior DIVU -> DIVU result committed and done=1, then 32 busy cycles, then hi=0, lo=15. With MD_EARLY_OUT_EN, MULTU A=5, B=1 -> lo=5, hi=0, done=1 in cycle T+2.
